// File: rtl/bch_ecc_ctrl_if.sv
// Host-side request/response handshake of the BCH read-path controller.
// The master is the requester and the slave is the controller.
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 32
`endif
`ifndef ECC_RED_N_BITS
`define ECC_RED_N_BITS 12
`endif

interface bch_ecc_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_W-1:0]         req_addr;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [`ECC_WORD_SIZE-1:0] rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/bch_ecc_ctrl.sv
// Read-path ECC controller: fetch word and check bits, run them through the shared BCH decoder,
// return the corrected word; with ECC_SCRUB_EN defined, errored words are re-encoded and written back.
`ifndef ECC_WORD_SIZE
`define ECC_WORD_SIZE 32
`endif
`ifndef ECC_RED_N_BITS
`define ECC_RED_N_BITS 12
`endif

module bch_ecc_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DEC_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bch_ecc_ctrl_if.slave              host,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_rd_valid,
  input  logic [`ECC_WORD_SIZE-1:0]  mem_rd_data,
  input  logic [`ECC_RED_N_BITS-1:0] mem_rd_ecc,
  output logic [`ECC_WORD_SIZE-1:0]  dec_read_bits,
  output logic [`ECC_RED_N_BITS-1:0] dec_read_ecc_bits,
  input  logic [`ECC_WORD_SIZE-1:0]  dec_ecc_msk,
  input  logic                       dec_ecc_err_det,
  output logic [`ECC_WORD_SIZE-1:0]  dec_write_bits,
  input  logic [`ECC_RED_N_BITS-1:0] dec_write_ecc_bits,
  output logic                       mem_wr_en,
  output logic [`ECC_WORD_SIZE-1:0]  mem_wr_data,
  output logic [`ECC_RED_N_BITS-1:0] mem_wr_ecc,
  input  logic                       mem_wr_ready,
  output logic [CNT_W-1:0]           err_cnt,
  input  logic                       err_cnt_clr
);

`ifdef ECC_SCRUB_EN
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_DEC, S_RSP, S_WB} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_DEC, S_RSP} state_t;
`endif

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q;
  logic [`ECC_WORD_SIZE-1:0]   rd_data_q;
  logic [`ECC_RED_N_BITS-1:0]  rd_ecc_q;
  logic [`ECC_WORD_SIZE-1:0]   rsp_data_q;
  logic                        rsp_err_q;
  logic [3:0]                  lat_q;
  logic [CNT_W-1:0]            err_cnt_q;
  logic                        dec_done;
  logic                        rsp_hs;

  // The decoder output is sampled in the last of DEC_LAT cycles with stable inputs.
  assign dec_done = (state_q == S_DEC) && (lat_q == 4'd1);
  assign rsp_hs   = (state_q == S_RSP) && host.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (host.req_valid) state_d = S_RD;
      S_RD:   state_d = S_WAIT;
      S_WAIT: if (mem_rd_valid) state_d = S_DEC;
      S_DEC:  if (lat_q == 4'd1) state_d = S_RSP;
      S_RSP: begin
        if (host.rsp_ready) begin
`ifdef ECC_SCRUB_EN
          state_d = rsp_err_q ? S_WB : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef ECC_SCRUB_EN
      S_WB:   if (mem_wr_ready) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    host.req_ready = rst_n && (state_q == S_IDLE);
    host.rsp_valid = (state_q == S_RSP);
    mem_rd_en      = (state_q == S_RD);
    mem_addr       = '0;
    mem_wr_en      = 1'b0;
    mem_wr_data    = '0;
    mem_wr_ecc     = '0;
    case (state_q)
      S_RD: mem_addr = addr_q;
`ifdef ECC_SCRUB_EN
      S_WB: begin
        mem_addr    = addr_q;
        mem_wr_en   = 1'b1;
        mem_wr_data = rsp_data_q;
        mem_wr_ecc  = dec_write_ecc_bits;
      end
`endif
      default: ;
    endcase
  end

`ifndef ECC_SCRUB_EN
  logic unused_wb;
  assign unused_wb = ^{dec_write_ecc_bits, mem_wr_ready};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_data_q  <= '0;
      rd_ecc_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      lat_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && host.req_valid) addr_q <= host.req_addr;
      if ((state_q == S_WAIT) && mem_rd_valid) begin
        rd_data_q <= mem_rd_data;
        rd_ecc_q  <= mem_rd_ecc;
        lat_q     <= 4'(DEC_LAT);
      end else if (state_q == S_DEC) begin
        lat_q <= lat_q - 4'd1;
      end
      if (dec_done) begin
        rsp_data_q <= rd_data_q ^ dec_ecc_msk;
        rsp_err_q  <= dec_ecc_err_det;
      end
      // Clear has priority over a coincident errored handshake.
      if (err_cnt_clr) begin
        err_cnt_q <= '0;
      end else if (rsp_hs && rsp_err_q && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign host.rsp_data     = rsp_data_q;
  assign host.rsp_err      = rsp_err_q;
  assign dec_read_bits     = rd_data_q;
  assign dec_read_ecc_bits = rd_ecc_q;
  assign dec_write_bits    = rsp_data_q;
  assign err_cnt           = err_cnt_q;

endmodule
